// File: rtl/side_servo_frame_scheduler_if.sv
// Configuration and PWM bus between the SideServos register file and the frame scheduler.
interface side_servo_frame_scheduler_if #(
    parameter int unsigned NUM_SERVOS = 4
) ();
    logic                       cfg_enable;
    logic [NUM_SERVOS*16-1:0]   cfg_target;
    logic [NUM_SERVOS-1:0]      servo_pwm;
    logic                       frame_start;
    logic                       busy;

    modport master (
        output cfg_enable, cfg_target,
        input  servo_pwm, frame_start, busy
    );

    modport slave (
        input  cfg_enable, cfg_target,
        output servo_pwm, frame_start, busy
    );
endinterface

// File: rtl/side_servo_frame_scheduler.sv
// Staggered side-servo frame scheduler: one clamped pulse per servo slot, one frame per FRAME_US.
// Optional per-frame slew limiting is enabled by defining SIDE_SERVO_SLEW_EN.
module side_servo_frame_scheduler #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned NUM_SERVOS  = 4,
    parameter int unsigned FRAME_US    = 20000,
    parameter int unsigned SLOT_US     = 2500,
    parameter int unsigned MIN_US      = 1000,
    parameter int unsigned MAX_US      = 2000,
    parameter int unsigned STEP_US     = 20
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    side_servo_frame_scheduler_if.slave   bus
);

    localparam int unsigned TICK_DIV = CLK_FREQ_HZ / 1_000_000;
    localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CW       = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;
    localparam int unsigned WW       = 16;
    localparam logic [WW-1:0] MID_W  = WW'((MIN_US + MAX_US) / 2);

    // Reject configurations the slot arithmetic cannot honour.
    if ((CLK_FREQ_HZ == 0) || (CLK_FREQ_HZ % 1_000_000 != 0)) begin : g_bad_clk
        $error("CLK_FREQ_HZ must be a non-zero multiple of 1 MHz");
    end
    if ((NUM_SERVOS < 1) || (NUM_SERVOS > 8) || (NUM_SERVOS * SLOT_US > FRAME_US)) begin : g_bad_slots
        $error("servo slots do not fit in the frame");
    end
    if ((MIN_US > MAX_US) || (MAX_US > SLOT_US) || (STEP_US == 0)) begin : g_bad_width
        $error("pulse width limits are inconsistent");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t                 state_q;
    logic [PW-1:0]          presc_q;
    logic [CW-1:0]          us_cnt_q;
    logic [WW-1:0]          cur_w_q [NUM_SERVOS];
    logic [NUM_SERVOS-1:0]  on_q;
    logic [NUM_SERVOS-1:0]  pwm_q;
    logic                   frame_start_q;
    logic                   busy_q;

    logic                   us_tick_c;
    logic                   frame_end_c;
    logic [CW-1:0]          us_cnt_d;
    logic [WW-1:0]          tgt_c [NUM_SERVOS];
    logic [WW-1:0]          w_d   [NUM_SERVOS];
    logic [NUM_SERVOS-1:0]  on_d;
    logic [NUM_SERVOS-1:0]  pwm_run_c;
    logic [NUM_SERVOS-1:0]  pwm_load_c;

    // Microsecond timebase, only advancing inside a frame.
    always_comb begin
        us_tick_c   = (state_q == S_RUN) && (presc_q == PW'(TICK_DIV - 1));
        frame_end_c = us_tick_c && (us_cnt_q == CW'(FRAME_US - 1));
        us_cnt_d    = us_tick_c ? (us_cnt_q + CW'(1)) : us_cnt_q;
    end

    for (genvar k = 0; k < NUM_SERVOS; k++) begin : g_ch
        localparam int unsigned BASE = 32'(k) * SLOT_US;
        logic [WW-1:0] raw_c;

        assign raw_c    = bus.cfg_target[16*k +: 16];
        assign on_d[k]  = (raw_c != '0);
        assign tgt_c[k] = (raw_c < WW'(MIN_US)) ? WW'(MIN_US) :
                          (raw_c > WW'(MAX_US)) ? WW'(MAX_US) : raw_c;

`ifdef SIDE_SERVO_SLEW_EN
        localparam logic signed [16:0] STEP_S = 17'(STEP_US);
        logic signed [16:0] diff_c;

        assign diff_c = $signed({1'b0, tgt_c[k]}) - $signed({1'b0, cur_w_q[k]});

        always_comb begin
            w_d[k] = tgt_c[k];
            if (diff_c > STEP_S) begin
                w_d[k] = cur_w_q[k] + WW'(STEP_US);
            end else if (diff_c < -STEP_S) begin
                w_d[k] = cur_w_q[k] - WW'(STEP_US);
            end
        end
`else
        assign w_d[k] = tgt_c[k];
`endif

        // Wrapped subtraction rejects counts before the slot start as well as past the width.
        assign pwm_run_c[k]  = on_q[k] && ((32'(us_cnt_d) - BASE) < 32'(cur_w_q[k]));
        assign pwm_load_c[k] = on_d[k] && (BASE == 32'd0) && (w_d[k] != '0);
    end

    // Frame FSM with registered outputs aligned to the state they describe.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q       <= S_IDLE;
            presc_q       <= '0;
            us_cnt_q      <= '0;
            on_q          <= '0;
            pwm_q         <= '0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
            for (int k = 0; k < NUM_SERVOS; k++) begin
                cur_w_q[k] <= MID_W;
            end
        end else begin
            frame_start_q <= 1'b0;
            pwm_q         <= '0;
            case (state_q)
                S_IDLE: begin
                    presc_q  <= '0;
                    us_cnt_q <= '0;
                    busy_q   <= 1'b0;
                    if (bus.cfg_enable) begin
                        state_q       <= S_LOAD;
                        frame_start_q <= 1'b1;
                        busy_q        <= 1'b1;
                    end
                end
                S_LOAD: begin
                    presc_q  <= '0;
                    us_cnt_q <= '0;
                    on_q     <= on_d;
                    busy_q   <= 1'b1;
                    state_q  <= S_RUN;
                    pwm_q    <= pwm_load_c;
                    for (int k = 0; k < NUM_SERVOS; k++) begin
                        if (on_d[k]) begin
                            cur_w_q[k] <= w_d[k];
                        end
                    end
                end
                S_RUN: begin
                    presc_q  <= us_tick_c ? '0 : (presc_q + PW'(1));
                    us_cnt_q <= us_cnt_d;
                    if (frame_end_c) begin
                        us_cnt_q <= '0;
                        if (bus.cfg_enable) begin
                            state_q       <= S_LOAD;
                            frame_start_q <= 1'b1;
                            busy_q        <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        pwm_q <= pwm_run_c;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.servo_pwm   = pwm_q;
    assign bus.frame_start = frame_start_q;
    assign bus.busy        = busy_q;

endmodule
